ntt_pair_gather: RTL

- Input stage of one NTT pipeline stage, placed directly upstream of the add_sub butterfly.
- Takes a serial coefficient stream, one coefficient per accepted cycle.
- Emits butterfly operand pairs (a[j], a[j+DIST]) on a two-element output, together with the twiddle index j.
- Uses a delay buffer and a sample counter. The downstream twiddle multiplier and add_sub consume the pairs directly.

---
 rtl/ntt_pkg.sv | 15 +
 rtl/ntt_delay_buf.sv | 30 +++
 rtl/ntt_pair_gather.sv | 97 +++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT datapath types and per-stage geometry helpers.
package ntt_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int Q          = 3329;
  localparam int N          = 256;

  typedef logic [DATA_WIDTH-1:0] coeff_t;

  // Butterfly distance of a given stage, so stages can be generated in a loop.
  function automatic int stage_dist(input int stage);
    return N >> (stage + 1);
  endfunction

endpackage

// File: rtl/ntt_delay_buf.sv
// Half-block delay line: one synchronous write port, one combinational read port.
// Kept as its own module so it can become a RAM macro with a registered read;
// the parent would then rebalance its output latency.
module ntt_delay_buf
  import ntt_pkg::*;
#(
  parameter int DIST = 64,
  parameter int AW   = (DIST > 1) ? $clog2(DIST) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  coeff_t        wdata,
  input  logic [AW-1:0] raddr,
  output coeff_t        rdata
);

  coeff_t mem [DIST];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Combinational read so the pair is formed in the same cycle as the live sample.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/ntt_pair_gather.sv
// Gathers a serial coefficient stream into butterfly pairs (a[j], a[j+DIST]).
// First half of each block is stored, second half is paired with it on the fly.
module ntt_pair_gather
  import ntt_pkg::*;
#(
  parameter int DIST  = 64,
  parameter int IDX_W = (DIST > 1) ? $clog2(DIST) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sync,
  input  coeff_t           in_data,
  output logic             out_valid,
  output coeff_t           out_data [2],
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             align_err
);

  localparam int CNT_W = (DIST > 1) ? IDX_W + 1 : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] eff_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] addr;
  logic             sync_hit;
  logic             phase;
  logic             buf_we;
  logic             pair_fire;
  coeff_t           buf_rdata;

  assign sync_hit  = in_valid & in_sync;
  assign eff_cnt   = sync_hit ? '0 : cnt;
  assign phase     = eff_cnt[CNT_W-1];
  assign buf_we    = in_valid & ~phase;
  assign pair_fire = in_valid & phase;
  assign cnt_nxt   = eff_cnt + CNT_W'(1);

  generate
    if (DIST > 1) begin : g_addr
      assign addr = eff_cnt[IDX_W-1:0];
    end else begin : g_addr_single
      assign addr = '0;
    end
  endgenerate

  ntt_delay_buf #(
    .DIST (DIST),
    .AW   (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (addr),
    .wdata (in_data),
    .raddr (addr),
    .rdata (buf_rdata)
  );

  // Sample counter: advances on accepted samples only, a sync restarts it at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (in_valid) begin
      cnt <= cnt_nxt;
    end
  end

  // Alignment error: a sync arrived while a block was partially received.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err <= 1'b0;
    end else begin
      align_err <= sync_hit & (cnt != '0);
    end
  end

  // Pair output register; data and index hold while no pair is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_idx     <= '0;
      out_data[0] <= '0;
      out_data[1] <= '0;
    end else begin
      out_valid <= pair_fire;
      out_last  <= pair_fire & (addr == IDX_W'(DIST - 1));
      if (pair_fire) begin
        out_idx     <= addr;
        out_data[0] <= buf_rdata;
        out_data[1] <= in_data;
      end
    end
  end

endmodule
